mcycle_unit: RTL
================

Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide engine in the Execute stage.
- Sits directly upstream of the Execute-stage multi-cycle holding register and feeds it M_Start, M_Done and MCycleResult.
- Accepts operands on a Start handshake and holds Busy so hazard logic stalls the pipeline.
- Pulses Done for one cycle with results valid.

Parameters:
- WIDTH, 32, operand width in bits; iteration count equals WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when idle or in the Done cycle.
- MCycleOp  input  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  product low word / quotient.
- Result2  output  WIDTH  product high word / remainder.
- Busy  output  1  unit occupied; stall request.
- Done  output  1  one-cycle pulse; results valid.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset: state IDLE, iteration counter 0, Result1=0, Result2=0, Busy=0, Done=0.
- RESET mid-operation aborts the operation. It returns to IDLE on the next edge with no Done pulse and results cleared.
- Accept:
  - Start=1 in IDLE or DONE during cycle 0 drives Busy=1 combinationally in that same cycle.
  - Operands and MCycleOp are captured at the cycle-0 edge.
  - For signed ops, operand magnitudes and result signs are captured.
- MUL: shift-add on magnitudes, 2*WIDTH-bit accumulator, one multiplier bit per cycle, WIDTH cycles (cycles 1..WIDTH).
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
- FIX: cycle WIDTH+1.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Results are registered.
- DONE: cycle WIDTH+2. Done=1, Busy=0, Result1/Result2 valid.
  - The next state is IDLE, or a new accept if Start=1.
- Latency: Done asserts exactly WIDTH+2 cycles after the accept cycle (34 for WIDTH=32). It does not depend on the data.
- Busy=1 from the accept cycle through cycle WIDTH+1 inclusive.
- Results hold their last values until the FIX of the next operation. They are stable in IDLE.
- Start while Busy (MUL/DIV/FIX) is ignored, with no effect on the operation in flight.
- Operand or MCycleOp changes after the accept cycle have no effect.
- Divide by zero: Result1 = all ones, Result2 = Operand1 (original, unsigned view), same latency, no trap. Applies to both signed and unsigned.
- Signed overflow, most-negative / -1: Result1 = most-negative value (wraps), Result2 = 0.
- Signed multiply: Result2:Result1 is the full 2*WIDTH-bit two's-complement product.
- Unsigned multiply: Result2:Result1 is the full unsigned product.

Optional Feature:
- Macro: MCYCLE_DIV_EN.
- Defined: division supported as above.
- Undefined:
  - The divider datapath and DIV state are omitted.
  - MCycleOp[1]=1 is still accepted and follows identical Busy/Done timing (WIDTH+2).
  - It returns Result1=0 and Result2=0.
  - The multiply path is unchanged.

Test Plan:
- Unsigned mul: Op=00, 7*6, Start pulsed at cycle 0 -> Busy=1 in cycles 0..33; Done=1 at cycle 34; Result1=42, Result2=0.
- Full-width mul: Op=00, 0xFFFFFFFF*0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE. Then Op=01, -3*5 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
- Signed div: Op=11, -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
  - Op=11, 0x80000000/0xFFFFFFFF -> Result1=0x80000000, Result2=0.
  - Op=10, 100/7 -> Result1=14, Result2=2.
- Divide by zero: Op=10, 100/0 -> Done at cycle 34, Result1=0xFFFFFFFF, Result2=100. With MCYCLE_DIV_EN undefined -> Result1=0, Result2=0, same timing.
- Handshake:
  - Start held high through an operation with operands changed at cycle 5 -> only one Done, at cycle 34, with the original result.
  - Start=1 in the Done cycle -> the new op is accepted and its Done arrives 34 cycles later.
- Reset mid-op: RESET=1 at cycle 10 of a multiply -> Busy=0 and Results=0 from cycle 11; no Done pulse; a later Start completes normally.

Source files
------------

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - iterative multi-cycle multiply/divide engine for the Execute stage
// Divider datapath is present only when MCYCLE_DIV_EN is defined; otherwise divide ops return zeros.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef MCYCLE_DIV_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} stateType;
`else
  typedef enum logic [2:0] {IDLE, MUL, FIX, DONE} stateType;
`endif

  stateType         state, nextState, startState;
  logic             accept, lastIter, neg1, neg2;
  logic [CW-1:0]    iterCount;
  logic [WIDTH-1:0] accHi, accLo, opB;
  logic             opDiv, negRes;
  logic [WIDTH:0]   mulSum;

  assign accept   = Start && (state == IDLE || state == DONE);
  assign lastIter = (iterCount == CW'(WIDTH - 1));
  assign neg1     = MCycleOp[0] & Operand1[WIDTH-1];
  assign neg2     = MCycleOp[0] & Operand2[WIDTH-1];
  // accLo holds the multiplier magnitude and shifts product low bits in from the top
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});

`ifdef MCYCLE_DIV_EN
  logic             negRem, divZero;
  logic [WIDTH-1:0] op1Orig;
  logic [WIDTH:0]   divShift, divDiff;

  // Restoring step: accHi is the partial remainder, accLo the dividend shifting into quotient
  assign divShift   = {accHi, accLo[WIDTH-1]};
  assign divDiff    = divShift - {1'b0, opB};
  assign startState = MCycleOp[1] ? DIV : MUL;
`else
  // Divide ops still run the MUL timing so Busy/Done look identical; FIX zeroes the result
  assign startState = MUL;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        Busy = accept;
        if (accept) nextState = startState;
      end
      MUL: begin
        Busy = 1'b1;
        if (lastIter) nextState = FIX;
      end
`ifdef MCYCLE_DIV_EN
      DIV: begin
        Busy = 1'b1;
        if (lastIter) nextState = FIX;
      end
`endif
      FIX: begin
        Busy      = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        Busy      = accept;
        nextState = accept ? startState : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      iterCount <= '0;
      accHi     <= '0;
      accLo     <= '0;
      opB       <= '0;
      opDiv     <= 1'b0;
      negRes    <= 1'b0;
      Result1   <= '0;
      Result2   <= '0;
`ifdef MCYCLE_DIV_EN
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      op1Orig   <= '0;
`endif
    end else if (accept) begin
      iterCount <= '0;
      accHi     <= '0;
      accLo     <= neg1 ? -Operand1 : Operand1;
      opB       <= neg2 ? -Operand2 : Operand2;
      opDiv     <= MCycleOp[1];
      negRes    <= neg1 ^ neg2;
`ifdef MCYCLE_DIV_EN
      negRem    <= neg1;
      divZero   <= (Operand2 == '0);
      op1Orig   <= Operand1;
`endif
    end else begin
      case (state)
        MUL: begin
          accHi     <= mulSum[WIDTH:1];
          accLo     <= {mulSum[0], accLo[WIDTH-1:1]};
          iterCount <= lastIter ? '0 : iterCount + CW'(1);
        end
`ifdef MCYCLE_DIV_EN
        DIV: begin
          if (!divDiff[WIDTH]) begin
            accHi <= divDiff[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], 1'b1};
          end else begin
            accHi <= divShift[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], 1'b0};
          end
          iterCount <= lastIter ? '0 : iterCount + CW'(1);
        end
`endif
        FIX: begin
          if (opDiv) begin
`ifdef MCYCLE_DIV_EN
            if (divZero) begin
              Result1 <= '1;
              Result2 <= op1Orig;
            end else begin
              Result1 <= negRes ? -accLo : accLo;
              Result2 <= negRem ? -accHi : accHi;
            end
`else
            Result1 <= '0;
            Result2 <= '0;
`endif
          end else begin
            {Result2, Result1} <= negRes ? -{accHi, accLo} : {accHi, accLo};
          end
        end
        default: ;
      endcase
    end
  end
endmodule
